// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - LSU-side and memory-side buses of the memory port arbiter
// Purpose: bundles the per-requester read/write handshakes and the single
//          memory-controller channel into one interface.
// Signals:
//   req_read_valid/address    LSU read request (per requester)
//   req_read_ready/data       read completion and data back to LSU
//   req_write_valid/address/data  LSU write request
//   req_write_ready           write completion back to LSU
//   mem_read_valid/address, mem_read_ready/data      controller read channel
//   mem_write_valid/address/data, mem_write_ready    controller write channel
// Modports: master = arbiter side, slave = LSUs plus memory controller.
interface mem_port_arbiter_if #(
  parameter int NUM_REQUESTERS = 4,
  parameter int ADDR_BITS      = 8,
  parameter int DATA_BITS      = 8
);
  logic [NUM_REQUESTERS-1:0] req_read_valid;
  logic [ADDR_BITS-1:0]      req_read_address  [NUM_REQUESTERS];
  logic [NUM_REQUESTERS-1:0] req_read_ready;
  logic [DATA_BITS-1:0]      req_read_data     [NUM_REQUESTERS];
  logic [NUM_REQUESTERS-1:0] req_write_valid;
  logic [ADDR_BITS-1:0]      req_write_address [NUM_REQUESTERS];
  logic [DATA_BITS-1:0]      req_write_data    [NUM_REQUESTERS];
  logic [NUM_REQUESTERS-1:0] req_write_ready;

  logic                      mem_read_valid;
  logic [ADDR_BITS-1:0]      mem_read_address;
  logic                      mem_read_ready;
  logic [DATA_BITS-1:0]      mem_read_data;
  logic                      mem_write_valid;
  logic [ADDR_BITS-1:0]      mem_write_address;
  logic [DATA_BITS-1:0]      mem_write_data;
  logic                      mem_write_ready;

  modport master (
    input  req_read_valid, req_read_address, req_write_valid, req_write_address,
           req_write_data, mem_read_ready, mem_read_data, mem_write_ready,
    output req_read_ready, req_read_data, req_write_ready,
           mem_read_valid, mem_read_address, mem_write_valid, mem_write_address,
           mem_write_data
  );

  modport slave (
    output req_read_valid, req_read_address, req_write_valid, req_write_address,
           req_write_data, mem_read_ready, mem_read_data, mem_write_ready,
    input  req_read_ready, req_read_data, req_write_ready,
           mem_read_valid, mem_read_address, mem_write_valid, mem_write_address,
           mem_write_data
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter sharing one memory channel among LSUs
// Purpose: serialises LSU read/write requests onto a single memory-controller
//          channel and relays ready/read data back to the granted requester.
// Ports:
//   clk       clock
//   reset     asynchronous active-high reset
//   bus       mem_port_arbiter_if.master (LSU handshakes + memory channel)
//   busy      high whenever the FSM is not IDLE
//   grant_id  requester currently served (0 when idle)
module mem_port_arbiter #(
  parameter int NUM_REQUESTERS = 4,
  parameter int ADDR_BITS      = 8,
  parameter int DATA_BITS      = 8,
  parameter int ID_BITS        = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1
) (
  input  logic               clk,
  input  logic               reset,
  mem_port_arbiter_if.master bus,
  output logic               busy,
  output logic [ID_BITS-1:0] grant_id
);
  localparam int N = NUM_REQUESTERS;
  localparam logic [ID_BITS-1:0] LAST_ID = ID_BITS'(N - 1);

  typedef enum logic [1:0] {IDLE, READ_WAIT, WRITE_WAIT, RELAY} state_t;

  state_t               state_q, state_d;
  logic [ID_BITS-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_BITS-1:0]   grant_q, grant_d;
  logic                 busy_q, busy_d;
  logic                 is_read_q, is_read_d;
  logic                 mrv_q, mrv_d;
  logic                 mwv_q, mwv_d;
  logic [ADDR_BITS-1:0] mra_q, mra_d;
  logic [ADDR_BITS-1:0] mwa_q, mwa_d;
  logic [DATA_BITS-1:0] mwd_q, mwd_d;
  logic [N-1:0]         rrdy_q, rrdy_d;
  logic [N-1:0]         wrdy_q, wrdy_d;
  logic [DATA_BITS-1:0] rdat_q [N];
  logic [DATA_BITS-1:0] rdat_d [N];

  logic                 found;
  logic [ID_BITS-1:0]   winner;
  logic [ID_BITS-1:0]   cand;
  logic                 relay_valid;

  // Round-robin scan starting at rr_ptr; the first requester with any pending
  // request wins.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int k = 0; k < N; k++) begin
      cand = ID_BITS'((int'(rr_ptr_q) + k) % N);
      if (!found && (bus.req_read_valid[cand] || bus.req_write_valid[cand])) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // RELAY waits on the valid that matches the operation actually served, so a
  // still-pending write behind a finished read does not stall the exit.
  assign relay_valid = is_read_q ? bus.req_read_valid[grant_q]
                                 : bus.req_write_valid[grant_q];

  // State register plus all registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      grant_q   <= '0;
      busy_q    <= 1'b0;
      is_read_q <= 1'b0;
      mrv_q     <= 1'b0;
      mwv_q     <= 1'b0;
      mra_q     <= '0;
      mwa_q     <= '0;
      mwd_q     <= '0;
      rrdy_q    <= '0;
      wrdy_q    <= '0;
      for (int i = 0; i < N; i++) rdat_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      grant_q   <= grant_d;
      busy_q    <= busy_d;
      is_read_q <= is_read_d;
      mrv_q     <= mrv_d;
      mwv_q     <= mwv_d;
      mra_q     <= mra_d;
      mwa_q     <= mwa_d;
      mwd_q     <= mwd_d;
      rrdy_q    <= rrdy_d;
      wrdy_q    <= wrdy_d;
      rdat_q    <= rdat_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       if (found) state_d = bus.req_read_valid[winner] ? READ_WAIT : WRITE_WAIT;
      READ_WAIT:  if (bus.mem_read_ready) state_d = RELAY;
      WRITE_WAIT: if (bus.mem_write_ready) state_d = RELAY;
      RELAY:      if (!relay_valid) state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs. Memory ready outside a WAIT state
  // falls through to the hold defaults and is therefore ignored.
  always_comb begin
    rr_ptr_d  = rr_ptr_q;
    grant_d   = grant_q;
    busy_d    = busy_q;
    is_read_d = is_read_q;
    mrv_d     = mrv_q;
    mwv_d     = mwv_q;
    mra_d     = mra_q;
    mwa_d     = mwa_q;
    mwd_d     = mwd_q;
    rrdy_d    = rrdy_q;
    wrdy_d    = wrdy_q;
    rdat_d    = rdat_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = winner;
          busy_d  = 1'b1;
          // Read takes priority; a simultaneous write stays pending for a later grant.
          if (bus.req_read_valid[winner]) begin
            is_read_d = 1'b1;
            mrv_d     = 1'b1;
            mra_d     = bus.req_read_address[winner];
          end else begin
            is_read_d = 1'b0;
            mwv_d     = 1'b1;
            mwa_d     = bus.req_write_address[winner];
            mwd_d     = bus.req_write_data[winner];
          end
        end
      end
      READ_WAIT: begin
        if (bus.mem_read_ready) begin
          mrv_d           = 1'b0;
          rdat_d[grant_q] = bus.mem_read_data;
          rrdy_d[grant_q] = 1'b1;
        end
      end
      WRITE_WAIT: begin
        if (bus.mem_write_ready) begin
          mwv_d           = 1'b0;
          wrdy_d[grant_q] = 1'b1;
        end
      end
      RELAY: begin
        if (!relay_valid) begin
          rrdy_d   = '0;
          wrdy_d   = '0;
          rr_ptr_d = (grant_q == LAST_ID) ? '0 : grant_q + ID_BITS'(1);
          busy_d   = 1'b0;
          grant_d  = '0;
        end
      end
      default: ;
    endcase
  end

  assign busy                  = busy_q;
  assign grant_id              = grant_q;
  assign bus.mem_read_valid    = mrv_q;
  assign bus.mem_read_address  = mra_q;
  assign bus.mem_write_valid   = mwv_q;
  assign bus.mem_write_address = mwa_q;
  assign bus.mem_write_data    = mwd_q;
  assign bus.req_read_ready    = rrdy_q;
  assign bus.req_write_ready   = wrdy_q;
  assign bus.req_read_data     = rdat_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;
  localparam int N = 4;
  localparam int EV_MRD = 0, EV_MWR = 1, EV_RDONE = 2, EV_WDONE = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       busy;
  logic [1:0] grant_id;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.NUM_REQUESTERS(N), .ADDR_BITS(8), .DATA_BITS(8)) bus ();

  mem_port_arbiter #(.NUM_REQUESTERS(N), .ADDR_BITS(8), .DATA_BITS(8)) dut (
    .clk(clk), .reset(reset), .bus(bus), .busy(busy), .grant_id(grant_id)
  );

  typedef struct {
    int         kind;
    int         id;
    logic [7:0] a;
    logic [7:0] d;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   errors = 0;
  int   mem_lat = 1;
  logic inj = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void expect_ev(int kind, int id, logic [7:0] a, logic [7:0] d);
    exp_t e;
    e.kind = kind; e.id = id; e.a = a; e.d = d;
    sb.push_back(e);
  endfunction

  task automatic got(input int kind, input int id, input logic [7:0] a, input logic [7:0] d);
    exp_t e;
    if (sb.size() == 0) begin
      tests++; errors++;
      $display("FAIL unexpected_event: got kind %0d id %0d, expected none", kind, id);
    end else begin
      e = sb.pop_front();
      check("ev_kind", kind, e.kind);
      check("ev_id", id, e.id);
      check("ev_addr", a, e.a);
      check("ev_data", d, e.d);
    end
  endtask

  // Monitor: rising edges of memory-side valids and requester readys.
  initial begin
    logic p_mrv, p_mwv;
    logic [N-1:0] p_rr, p_wr;
    p_mrv = 0; p_mwv = 0; p_rr = '0; p_wr = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (bus.mem_read_valid && !p_mrv) begin
          check("one_mem_valid", bus.mem_write_valid, 0);
          check("busy_at_grant", busy, 1);
          got(EV_MRD, grant_id, bus.mem_read_address, 8'h00);
        end
        if (bus.mem_write_valid && !p_mwv) begin
          check("one_mem_valid", bus.mem_read_valid, 0);
          check("busy_at_grant", busy, 1);
          got(EV_MWR, grant_id, bus.mem_write_address, bus.mem_write_data);
        end
        for (int i = 0; i < N; i++) begin
          if (bus.req_read_ready[i] && !p_rr[i]) got(EV_RDONE, i, 8'h00, bus.req_read_data[i]);
          if (bus.req_write_ready[i] && !p_wr[i]) got(EV_WDONE, i, 8'h00, 8'h00);
        end
      end
      p_mrv = bus.mem_read_valid;
      p_mwv = bus.mem_write_valid;
      p_rr  = bus.req_read_ready;
      p_wr  = bus.req_write_ready;
    end
  end

  // Memory controller model: answers after mem_lat cycles, read data = addr ^ 0xBB.
  initial begin
    int cnt;
    cnt = 0;
    bus.mem_read_ready = 0; bus.mem_write_ready = 0; bus.mem_read_data = 8'h00;
    forever begin
      @(negedge clk);
      bus.mem_read_ready = 0; bus.mem_write_ready = 0;
      if (inj) begin
        bus.mem_read_ready = 1; bus.mem_write_ready = 1; bus.mem_read_data = 8'hEE; cnt = 0;
      end else if (reset || !(bus.mem_read_valid || bus.mem_write_valid)) begin
        cnt = 0;
      end else begin
        cnt++;
        if (cnt >= mem_lat) begin
          cnt = 0;
          if (bus.mem_read_valid) begin
            bus.mem_read_ready = 1;
            bus.mem_read_data  = bus.mem_read_address ^ 8'hBB;
          end else begin
            bus.mem_write_ready = 1;
          end
        end
      end
    end
  end

  task automatic do_read(input int id, input logic [7:0] addr, input logic [7:0] exp, input int hold);
    int t;
    t = 0;
    @(negedge clk);
    bus.req_read_valid[id] = 1; bus.req_read_address[id] = addr;
    while (!bus.req_read_ready[id] && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) begin
      tests++; errors++;
      $display("FAIL read_timeout: req %0d got no ready, expected ready", id);
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("read_ready_held", bus.req_read_ready[id], 1);
      check("read_data_held", bus.req_read_data[id], exp);
    end
    bus.req_read_valid[id] = 0;
    @(negedge clk);
    check("read_ready_cleared", bus.req_read_ready[id], 0);
    @(negedge clk);
  endtask

  task automatic do_write(input int id, input logic [7:0] addr, input logic [7:0] data);
    int t;
    t = 0;
    @(negedge clk);
    bus.req_write_valid[id] = 1; bus.req_write_address[id] = addr; bus.req_write_data[id] = data;
    while (!bus.req_write_ready[id] && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) begin
      tests++; errors++;
      $display("FAIL write_timeout: req %0d got no ready, expected ready", id);
    end
    bus.req_write_valid[id] = 0;
    @(negedge clk);
    check("write_ready_cleared", bus.req_write_ready[id], 0);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk); reset = 1;
    repeat (3) @(negedge clk);
    reset = 0;
  endtask

  initial begin
    int t;
    bus.req_read_valid = '0; bus.req_write_valid = '0;
    for (int i = 0; i < N; i++) begin
      bus.req_read_address[i] = 8'h00; bus.req_write_address[i] = 8'h00; bus.req_write_data[i] = 8'h00;
    end
    repeat (2) @(negedge clk);
    // Reset state
    check("rst_busy", busy, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_mem_read_valid", bus.mem_read_valid, 0);
    check("rst_mem_write_valid", bus.mem_write_valid, 0);
    check("rst_mem_addr", {bus.mem_read_address, bus.mem_write_address, bus.mem_write_data}, 0);
    check("rst_ready", {bus.req_read_ready, bus.req_write_ready}, 0);
    for (int i = 0; i < N; i++) check("rst_read_data", bus.req_read_data[i], 0);
    reset = 0;

    // 1: single read, memory answers 2 cycles after the request
    mem_lat = 2;
    expect_ev(EV_MRD, 0, 8'h10, 8'h00);
    expect_ev(EV_RDONE, 0, 8'h00, 8'hAB);
    do_read(0, 8'h10, 8'hAB, 3);
    mem_lat = 1;

    // 2: four concurrent reads from a fresh reset
    apply_reset();
    expect_ev(EV_MRD, 0, 8'h30, 8'h00); expect_ev(EV_RDONE, 0, 8'h00, 8'h8B);
    expect_ev(EV_MRD, 1, 8'h31, 8'h00); expect_ev(EV_RDONE, 1, 8'h00, 8'h8A);
    expect_ev(EV_MRD, 2, 8'h32, 8'h00); expect_ev(EV_RDONE, 2, 8'h00, 8'h89);
    expect_ev(EV_MRD, 3, 8'h33, 8'h00); expect_ev(EV_RDONE, 3, 8'h00, 8'h88);
    fork
      do_read(0, 8'h30, 8'h8B, 0);
      do_read(1, 8'h31, 8'h8A, 0);
      do_read(2, 8'h32, 8'h89, 0);
      do_read(3, 8'h33, 8'h88, 0);
    join
    // rr_ptr wrapped to 0: req0 beats req3
    expect_ev(EV_MRD, 0, 8'h60, 8'h00); expect_ev(EV_RDONE, 0, 8'h00, 8'hDB);
    expect_ev(EV_MRD, 3, 8'h63, 8'h00); expect_ev(EV_RDONE, 3, 8'h00, 8'hD8);
    fork
      do_read(3, 8'h63, 8'hD8, 0);
      do_read(0, 8'h60, 8'hDB, 0);
    join

    // 3: read and write together from req2, read first
    expect_ev(EV_MRD, 2, 8'h20, 8'h00); expect_ev(EV_RDONE, 2, 8'h00, 8'h9B);
    expect_ev(EV_MWR, 2, 8'h21, 8'h5C); expect_ev(EV_WDONE, 2, 8'h00, 8'h00);
    fork
      do_read(2, 8'h20, 8'h9B, 0);
      do_write(2, 8'h21, 8'h5C);
    join

    // 4: req1 served, then req1 and req3 together -> req3 first
    expect_ev(EV_MRD, 1, 8'h41, 8'h00); expect_ev(EV_RDONE, 1, 8'h00, 8'hFA);
    do_read(1, 8'h41, 8'hFA, 0);
    expect_ev(EV_MRD, 3, 8'h43, 8'h00); expect_ev(EV_RDONE, 3, 8'h00, 8'hF8);
    expect_ev(EV_MRD, 1, 8'h42, 8'h00); expect_ev(EV_RDONE, 1, 8'h00, 8'hF9);
    fork
      do_read(1, 8'h42, 8'hF9, 0);
      do_read(3, 8'h43, 8'hF8, 0);
    join

    // 5: reset in READ_WAIT with rr_ptr at 2, then scan restarts at 0
    apply_reset();
    expect_ev(EV_MRD, 1, 8'h01, 8'h00); expect_ev(EV_RDONE, 1, 8'h00, 8'hBA);
    do_read(1, 8'h01, 8'hBA, 0);
    mem_lat = 1000;
    expect_ev(EV_MRD, 2, 8'h02, 8'h00);
    @(negedge clk);
    bus.req_read_valid[2] = 1; bus.req_read_address[2] = 8'h02;
    repeat (3) @(negedge clk);
    check("t5_in_read_wait", bus.mem_read_valid, 1);
    #1 reset = 1;
    #1;
    check("t5_mem_read_valid", bus.mem_read_valid, 0);
    check("t5_busy", busy, 0);
    check("t5_grant_id", grant_id, 0);
    check("t5_ready", {bus.req_read_ready, bus.req_write_ready}, 0);
    bus.req_read_valid[2] = 0;
    @(negedge clk); reset = 0; mem_lat = 1;
    expect_ev(EV_MRD, 1, 8'h11, 8'h00); expect_ev(EV_RDONE, 1, 8'h00, 8'hAA);
    expect_ev(EV_MRD, 3, 8'h13, 8'h00); expect_ev(EV_RDONE, 3, 8'h00, 8'hA8);
    fork
      do_read(3, 8'h13, 8'hA8, 0);
      do_read(1, 8'h11, 8'hAA, 0);
    join

    // 6: memory ready pulsed while idle is ignored
    @(negedge clk); inj = 1;
    @(negedge clk); inj = 0;
    repeat (3) @(negedge clk);
    check("t6_busy", busy, 0);
    check("t6_ready", {bus.req_read_ready, bus.req_write_ready}, 0);
    check("t6_mem_valid", {bus.mem_read_valid, bus.mem_write_valid}, 0);
    expect_ev(EV_MRD, 0, 8'h56, 8'h00); expect_ev(EV_RDONE, 0, 8'h00, 8'hED);
    do_read(0, 8'h56, 8'hED, 0);

    // 7: requester drops valid during READ_WAIT; ready pulses once
    mem_lat = 3;
    expect_ev(EV_MRD, 0, 8'h44, 8'h00); expect_ev(EV_RDONE, 0, 8'h00, 8'hFF);
    @(negedge clk); bus.req_read_valid[0] = 1; bus.req_read_address[0] = 8'h44;
    @(negedge clk); bus.req_read_valid[0] = 0;
    t = 0;
    while (!bus.req_read_ready[0] && t < 50) begin @(negedge clk); t++; end
    check("t7_ready_seen", bus.req_read_ready[0], 1);
    @(negedge clk);
    check("t7_ready_pulse", bus.req_read_ready[0], 0);
    check("t7_busy_after", busy, 0);
    mem_lat = 1;

    t = 0;
    while (sb.size() != 0 && t < 100) begin @(negedge clk); t++; end
    check("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
